pipelined_datapath: RTL and testbench

Two-stage (EX, WB) parametrised datapath: register file, ALU with carry/overflow, on-chip data memory and write-back operand forwarding. Successor of the single-cycle 16-bit datapath; generalised in data width, register count and memory depth, with working loads/stores and registered status flags. Sits under the control unit, which issues one operation per cycle via `in_valid`.

---
 rtl/pipelined_datapath_if.sv | 38 +++
 rtl/pipelined_datapath.sv | 136 +++++++++++++
 tb/tb_pipelined_datapath.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_datapath_if.sv
// Operation and status bundle between the control unit (master) and the
// two-stage datapath (slave).
interface pipelined_datapath_if #(
   parameter int WIDTH  = 16,
   parameter int REG_AW = 3
);
   logic              in_valid;
   logic              rf_write;
   logic [REG_AW-1:0] rs_addr;
   logic [REG_AW-1:0] rt_addr;
   logic [REG_AW-1:0] rd_addr;
   logic [WIDTH-1:0]  imm_data;
   logic              imm_sel;
   logic [3:0]        alu_sel;
   logic              mem_read;
   logic              mem_write;
   logic [WIDTH-1:0]  r_top_data;
   logic [WIDTH-1:0]  read_data;
   logic              out_valid;
   logic              zero_flag;
   logic              pos_flag;
   logic              carry_flag;
   logic              ovf_flag;

   modport master (
      output in_valid, rf_write, rs_addr, rt_addr, rd_addr, imm_data, imm_sel,
             alu_sel, mem_read, mem_write,
      input  r_top_data, read_data, out_valid, zero_flag, pos_flag, carry_flag,
             ovf_flag
   );

   modport slave (
      input  in_valid, rf_write, rs_addr, rt_addr, rd_addr, imm_data, imm_sel,
             alu_sel, mem_read, mem_write,
      output r_top_data, read_data, out_valid, zero_flag, pos_flag, carry_flag,
             ovf_flag
   );
endinterface

// File: rtl/pipelined_datapath.sv
// Two-stage (EX, WB) datapath: register file, ALU with flags, data memory.
// Define PIPELINED_DATAPATH_FWD_EN to forward the WB value into EX operands.
module pipelined_datapath #(
   parameter int WIDTH  = 16,
   parameter int REG_AW = 3,
   parameter int MEM_AW = 8
) (
   input logic                 clock,
   input logic                 reset,
   pipelined_datapath_if.slave bus
);
   localparam int NUM_REGS = 2**REG_AW;
   localparam int SH_W     = $clog2(WIDTH);

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SLL, ALU_SRL,
      ALU_SRA, ALU_SLT, ALU_PASS_B, ALU_PASS_A
   } alu_op_e;

   typedef struct packed {
      logic              valid;
      logic              rf_write;
      logic [REG_AW-1:0] rd;
      logic [WIDTH-1:0]  result;
      logic [WIDTH-1:0]  store_data;
      logic              mem_read;
      logic              mem_write;
   } wb_t;

   logic [WIDTH-1:0] regs [NUM_REGS];
   logic [WIDTH-1:0] mem  [2**MEM_AW];
   wb_t              wb;

   logic [WIDTH-1:0]  wb_value;
   logic [MEM_AW-1:0] wb_addr;
   logic [WIDTH-1:0]  op_a, rt_val, op_b, alu_res;
   logic [WIDTH:0]    sum_ext, diff_ext;
   logic [SH_W-1:0]   shamt;
   logic              alu_carry, alu_ovf;

   assign wb_addr  = wb.result[MEM_AW-1:0];
   // A combined load+store is a store; its write-back value is the address.
   assign wb_value = (wb.mem_read && !wb.mem_write) ? mem[wb_addr] : wb.result;

`ifdef PIPELINED_DATAPATH_FWD_EN
   logic wb_fwd;
   assign wb_fwd = wb.valid && wb.rf_write;
   assign op_a   = (wb_fwd && wb.rd == bus.rs_addr) ? wb_value : regs[bus.rs_addr];
   assign rt_val = (wb_fwd && wb.rd == bus.rt_addr) ? wb_value : regs[bus.rt_addr];
`else
   assign op_a   = regs[bus.rs_addr];
   assign rt_val = regs[bus.rt_addr];
`endif

   assign op_b     = bus.imm_sel ? bus.imm_data : rt_val;
   assign shamt    = op_b[SH_W-1:0];
   assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
   assign diff_ext = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (bus.alu_sel)
         ALU_ADD: begin
            alu_res   = sum_ext[WIDTH-1:0];
            alu_carry = sum_ext[WIDTH];
            alu_ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_res   = diff_ext[WIDTH-1:0];
            alu_carry = diff_ext[WIDTH];
            alu_ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
         end
         ALU_AND:    alu_res = op_a & op_b;
         ALU_OR:     alu_res = op_a | op_b;
         ALU_XOR:    alu_res = op_a ^ op_b;
         ALU_NOT:    alu_res = ~op_a;
         ALU_SLL:    alu_res = op_a << shamt;
         ALU_SRL:    alu_res = op_a >> shamt;
         ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> shamt);
         ALU_SLT:    alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_PASS_B: alu_res = op_b;
         ALU_PASS_A: alu_res = op_a;
         default:    alu_res = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wb             <= '0;
         bus.zero_flag  <= 1'b0;
         bus.pos_flag   <= 1'b0;
         bus.carry_flag <= 1'b0;
         bus.ovf_flag   <= 1'b0;
      end else begin
         wb.valid <= bus.in_valid;
         if (bus.in_valid) begin
            wb.rf_write    <= bus.rf_write;
            wb.rd          <= bus.rd_addr;
            wb.result      <= alu_res;
            wb.store_data  <= rt_val;
            wb.mem_read    <= bus.mem_read;
            wb.mem_write   <= bus.mem_write;
            bus.zero_flag  <= (alu_res == '0);
            bus.pos_flag   <= ~alu_res[WIDTH-1];
            bus.carry_flag <= alu_carry;
            bus.ovf_flag   <= alu_ovf;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         bus.read_data <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= wb.valid;
         if (wb.valid && wb.rf_write)
            regs[wb.rd] <= wb_value;
         if (wb.valid && wb.mem_read && !wb.mem_write)
            bus.read_data <= wb_value;
      end
   end

   // NOTE: memory has no reset; a reset only cancels the pending store through wb.valid.
   always_ff @(posedge clock) begin
      if (wb.valid && wb.mem_write)
         mem[wb_addr] <= wb.store_data;
   end

   assign bus.r_top_data = regs[NUM_REGS-1];
endmodule

// File: tb/tb_pipelined_datapath.sv
// Self-checking bench for pipelined_datapath: operation-level model plus
// directed vectors; follows PIPELINED_DATAPATH_FWD_EN like the design.
module tb_pipelined_datapath;
   localparam int WIDTH  = 16;
   localparam int REG_AW = 3;
   localparam int MEM_AW = 8;
`ifdef PIPELINED_DATAPATH_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   pipelined_datapath_if #(.WIDTH(WIDTH), .REG_AW(REG_AW)) bus ();
   pipelined_datapath #(.WIDTH(WIDTH), .REG_AW(REG_AW), .MEM_AW(MEM_AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: committed registers/memory plus the one operation sitting in WB.
   typedef struct {
      bit          valid;
      bit          rf_write;
      bit [2:0]    rd;
      logic [15:0] res;
      logic [15:0] sdata;
      bit          mrd;
      bit          mwr;
   } pend_t;

   logic [15:0] m_regs [8];
   logic [15:0] m_mem  [256];
   pend_t       pend;
   logic        e_out_valid, e_zero, e_pos, e_carry, e_ovf;
   logic [15:0] e_read_data;
   bit          cmp_en = 1'b0;

   function automatic logic [15:0] pend_wb();
      return (pend.mrd && !pend.mwr) ? m_mem[pend.res[7:0]] : pend.res;
   endfunction

   function automatic logic [15:0] src(input bit [2:0] r);
      if (FWD && pend.valid && pend.rf_write && pend.rd == r) return pend_wb();
      return m_regs[r];
   endfunction

   task automatic model_alu(input bit [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            output logic [15:0] r, output bit c, output bit v);
      int sa = $signed(a);
      int sb = $signed(b);
      int s;
      int n = int'(b[3:0]);
      c = 1'b0;
      v = 1'b0;
      case (op)
         0: begin s = int'(a) + int'(b); r = s[15:0]; c = (s > 65535);
                  v = (sa + sb > 32767) || (sa + sb < -32768); end
         1: begin s = int'(a) - int'(b); r = s[15:0]; c = (a >= b);
                  v = (sa - sb > 32767) || (sa - sb < -32768); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = ~a;
         6: r = a << n;
         7: r = a >> n;
         8: r = (a >> n) | (a[15] ? ~(16'hFFFF >> n) : 16'h0000);
         9: r = (sa < sb) ? 16'd1 : 16'd0;
         10: r = b;
         11: r = a;
         default: r = 16'h0000;
      endcase
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      pend.valid  = 1'b0;
      e_out_valid = 1'b0;
      e_read_data = 16'h0000;
      {e_zero, e_pos, e_carry, e_ovf} = 4'b0000;
   endtask

   task automatic issue(input bit v, input bit [3:0] alu, input bit [2:0] rd, input bit [2:0] rs,
                        input bit [2:0] rt, input logic [15:0] imm, input bit isel,
                        input bit rfw, input bit mrd, input bit mwr);
      logic [15:0] a, rtv, b, r, wbv;
      bit c, o;
      bus.in_valid = v;   bus.alu_sel  = alu;  bus.rd_addr   = rd;
      bus.rs_addr  = rs;  bus.rt_addr  = rt;   bus.imm_data  = imm;
      bus.imm_sel  = isel; bus.rf_write = rfw; bus.mem_read  = mrd;
      bus.mem_write = mwr;
      a   = src(rs);
      rtv = src(rt);
      b   = isel ? imm : rtv;
      model_alu(alu, a, b, r, c, o);
      @(posedge clock);
      e_out_valid = pend.valid;
      if (pend.valid) begin
         wbv = pend_wb();
         if (pend.rf_write) m_regs[pend.rd] = wbv;
         if (pend.mrd && !pend.mwr) e_read_data = wbv;
         if (pend.mwr) m_mem[pend.res[7:0]] = pend.sdata;
      end
      if (v) begin
         e_zero = (r == 16'h0000); e_pos = ~r[15]; e_carry = c; e_ovf = o;
      end
      pend.valid = v;  pend.rf_write = rfw; pend.rd = rd; pend.res = r;
      pend.sdata = rtv; pend.mrd = mrd; pend.mwr = mwr;
      #1;
   endtask

   task automatic bubble();                    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic alu_imm(input bit [3:0] op, input bit [2:0] rd, input bit [2:0] rs,
                          input logic [15:0] imm);  issue(1, op, rd, rs, 0, imm, 1, 1, 0, 0); endtask
   task automatic alu_rr(input bit [3:0] op, input bit [2:0] rd, input bit [2:0] rs,
                         input bit [2:0] rt);       issue(1, op, rd, rs, rt, 0, 0, 1, 0, 0); endtask
   task automatic store(input logic [15:0] addr, input bit [2:0] rt);
      issue(1, 0, 0, 0, rt, addr, 1, 0, 0, 1);
   endtask
   task automatic load(input bit [2:0] rd, input logic [15:0] addr);
      issue(1, 0, rd, 0, 0, addr, 1, 1, 1, 0);
   endtask

   always @(negedge clock) begin
      if (cmp_en && !reset) begin
         check("out_valid",  bus.out_valid,  e_out_valid);
         check("read_data",  bus.read_data,  e_read_data);
         check("r_top_data", bus.r_top_data, m_regs[7]);
         check("flags", {bus.zero_flag, bus.pos_flag, bus.carry_flag, bus.ovf_flag},
               {e_zero, e_pos, e_carry, e_ovf});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bus.in_valid = 0; bus.rf_write = 0; bus.rs_addr = 0; bus.rt_addr = 0;
      bus.rd_addr = 0; bus.imm_data = 0; bus.imm_sel = 0; bus.alu_sel = 0;
      bus.mem_read = 0; bus.mem_write = 0;
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      cmp_en = 1'b1;

      bubble();
      check("reset_flags", {bus.zero_flag, bus.pos_flag, bus.carry_flag, bus.ovf_flag}, 4'b0000);
      alu_imm(0, 7, 0, 16'd5);
      check("addi_valid_early", bus.out_valid, 1'b0);
      check("addi_pos", bus.pos_flag, 1'b1);
      bubble();
      check("addi_r7", bus.r_top_data, 16'd5);
      check("addi_valid", bus.out_valid, 1'b1);
      bubble();
      check("valid_pulse_end", bus.out_valid, 1'b0);

      alu_imm(10, 1, 0, 16'hFFFF); bubble();
      alu_imm(0, 2, 1, 16'd1);
      check("wrap_zero_carry_ovf", {bus.zero_flag, bus.carry_flag, bus.ovf_flag}, 3'b110);
      alu_imm(10, 1, 0, 16'h7FFF); bubble();
      alu_imm(0, 2, 1, 16'd1);
      check("ovf_pos", {bus.pos_flag, bus.ovf_flag}, 2'b01);
      bubble(); alu_rr(11, 7, 2, 0); bubble();
      check("ovf_result", bus.r_top_data, 16'h8000);

      alu_imm(10, 1, 0, 16'd0); bubble();
      alu_imm(10, 1, 0, 16'd3);
      alu_rr(0, 2, 1, 1);
      bubble(); alu_rr(11, 7, 2, 0); bubble();
      check("back_to_back", bus.r_top_data, FWD ? 16'd6 : 16'd0);

      alu_imm(10, 1, 0, 16'hABCD); bubble();
      store(16'h01FF, 1);
      load(3, 16'h00FF);
      alu_imm(0, 7, 3, 16'd0);
      check("load_data", bus.read_data, 16'hABCD);
      bubble();
      check("load_use", bus.r_top_data, FWD ? 16'hABCD : 16'h0000);
      alu_rr(11, 7, 3, 0); bubble();
      check("load_r3", bus.r_top_data, 16'hABCD);

      alu_imm(10, 1, 0, 16'd3); alu_imm(10, 2, 0, 16'd5); bubble();
      alu_rr(1, 7, 1, 2);
      check("sub_carry", bus.carry_flag, 1'b0);
      bubble();
      check("sub_result", bus.r_top_data, 16'hFFFE);
      alu_rr(9, 7, 1, 2); bubble();
      check("slt_result", bus.r_top_data, 16'd1);
      alu_imm(10, 1, 0, 16'h8000); bubble();
      alu_imm(8, 7, 1, 16'd4); bubble();
      check("sra_result", bus.r_top_data, 16'hF800);

      alu_imm(10, 1, 0, 16'hC3A5); alu_imm(10, 2, 0, 16'h0005); bubble();
      for (int op = 0; op < 16; op++) alu_rr(4'(op), 7, 1, 2);
      for (int op = 0; op < 16; op++) alu_imm(4'(op), 7, 1, 16'hFFF3);
      bubble();

      for (int i = 0; i < 16; i++) begin
         alu_imm(10, 4, 0, 16'h1000 + 16'(i));
         store(16'(i), 4);
      end
      alu_imm(10, 5, 0, 16'h1234); bubble();
      store(16'h0010, 5); bubble(); bubble();

      alu_imm(10, 5, 0, 16'h5555); bubble();
      store(16'h0010, 5);
      bus.in_valid = 1'b0;
      #2 reset = 1'b1;
      model_reset();
      check("reset_out_valid", bus.out_valid, 1'b0);
      @(posedge clock);
      #1 reset = 1'b0;
      check("reset_regs", bus.r_top_data, 16'h0000);
      bubble();
      check("reset_no_wb", bus.out_valid, 1'b0);
      load(3, 16'h0010); bubble();
      check("reset_mem_kept", bus.read_data, 16'h1234);

      for (int i = 0; i < 300; i++) begin
         int k = $urandom_range(0, 7);
         bit v = ($urandom_range(0, 5) != 0);
         if (k == 0)      issue(v, 10, 3'($urandom_range(1, 7)), 0, 0, 16'($urandom_range(0, 16)), 1, 1'($urandom), 1, 0);
         else if (k == 1) issue(v, 10, 3'($urandom_range(1, 7)), 0, 3'($urandom), 16'($urandom_range(0, 16)), 1, 1'($urandom), 0, 1);
         else if (k == 2) issue(v, 10, 3'($urandom_range(1, 7)), 0, 3'($urandom), 16'($urandom_range(0, 16)), 1, 1'($urandom), 1, 1);
         else issue(v, 4'($urandom), 3'($urandom_range(1, 7)), 3'($urandom), 3'($urandom),
                    16'($urandom), 1'($urandom), 1'($urandom), 0, 0);
      end
      bubble(); bubble();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
